// File: rtl/countdown_pkg.sv
// Shared constants for the two-digit BCD countdown timer.
//   - FSM state encodings (IDLE, RUN, PAUSED, EXPIRED)
//   - Active-low 7-segment patterns {g,f,e,d,c,b,a}
//   - BCD preset clamp helper
package countdown_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSED  = 2'd2;
  localparam logic [STATE_W-1:0] ST_EXPIRED = 2'd3;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Preset digits above 9 saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
//   bcd   in  4  BCD digit
//   seg_c out 7  active-low {g,f,e,d,c,b,a}; non-BCD input shows blank
module bcd_to_seg7
  import countdown_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (bcd <= 4'd9) seg_c = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer (00-99 s) with active-low 7-segment outputs.
//   clk          system clock
//   clrn         synchronous reset, active-low
//   en           enable; 0 forces IDLE with digits 00
//   load         1-cycle strobe: latch clamped preset and start
//   pause        level: freezes count and tick divider
//   preset_tens  BCD tens of preset (>9 clamps to 9)
//   preset_ones  BCD ones of preset (>9 clamps to 9)
//   done         registered, 1 while EXPIRED
//   seg1, seg0   registered tens / ones display patterns
// Optional build macro COUNTDOWN_BLINK_EN: displays blink "00"/blank each
// tick while EXPIRED (divider keeps running there).
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       en,
  input  logic       load,
  input  logic       pause,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic       done,
  output logic [6:0] seg1,
  output logic [6:0] seg0
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic               done_q, done_d;
  logic [SEG_W-1:0]   seg1_q, seg1_d;
  logic [SEG_W-1:0]   seg0_q, seg0_d;
`ifdef COUNTDOWN_BLINK_EN
  logic               blink_q, blink_d;
`endif

  logic [3:0]       ld_tens_c, ld_ones_c;
  logic             tick_c;
  logic [CNT_W-1:0] cnt_next_c;
  logic [SEG_W-1:0] dec_tens_c, dec_ones_c;

  bcd_to_seg7 u_dec_tens (.bcd(tens_q), .seg_c(dec_tens_c));
  bcd_to_seg7 u_dec_ones (.bcd(ones_q), .seg_c(dec_ones_c));

  assign ld_tens_c  = bcd_clamp(preset_tens);
  assign ld_ones_c  = bcd_clamp(preset_ones);
  // Only consumed in states where the divider is advancing.
  assign tick_c     = (tick_cnt_q == CNT_MAX);
  assign cnt_next_c = tick_c ? '0 : tick_cnt_q + CNT_W'(1);

  // Next-state, BCD datapath and display logic; priority !en > load > pause > tick.
  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    tick_cnt_d = tick_cnt_q;
`ifdef COUNTDOWN_BLINK_EN
    blink_d    = 1'b0;
`endif

    if (!en) begin
      state_d    = ST_IDLE;
      tens_d     = 4'd0;
      ones_d     = 4'd0;
      tick_cnt_d = '0;
    end else if (load) begin
      tens_d     = ld_tens_c;
      ones_d     = ld_ones_c;
      tick_cnt_d = '0;
      if ((ld_tens_c == 4'd0) && (ld_ones_c == 4'd0)) state_d = ST_EXPIRED;
      else if (pause)                                 state_d = ST_PAUSED;
      else                                            state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            tick_cnt_d = cnt_next_c;
            if (tick_c) begin
              // BCD borrow; 00 is never decremented further.
              if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else if (tens_q != 4'd0) begin
                tens_d = tens_q - 4'd1;
                ones_d = 4'd9;
              end
              if ((tens_q == 4'd0) && (ones_q <= 4'd1)) state_d = ST_EXPIRED;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
`ifdef COUNTDOWN_BLINK_EN
          tick_cnt_d = cnt_next_c;
          blink_d    = blink_q ^ tick_c;
`endif
        end
        default: ;
      endcase
    end

    done_d = en && (state_q == ST_EXPIRED);

    if (!en) begin
      seg1_d = SEG_DIGIT[0];
      seg0_d = SEG_DIGIT[0];
`ifdef COUNTDOWN_BLINK_EN
    end else if (blink_q) begin
      seg1_d = SEG_BLANK;
      seg0_d = SEG_BLANK;
`endif
    end else begin
      seg1_d = dec_tens_c;
      seg0_d = dec_ones_c;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      tick_cnt_q <= '0;
      done_q     <= 1'b0;
      seg1_q     <= SEG_DIGIT[0];
      seg0_q     <= SEG_DIGIT[0];
`ifdef COUNTDOWN_BLINK_EN
      blink_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      tick_cnt_q <= tick_cnt_d;
      done_q     <= done_d;
      seg1_q     <= seg1_d;
      seg0_q     <= seg0_d;
`ifdef COUNTDOWN_BLINK_EN
      blink_q    <= blink_d;
`endif
    end
  end

  assign done = done_q;
  assign seg1 = seg1_q;
  assign seg0 = seg0_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with TICK_CYCLES=4.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       clrn;
  logic       en;
  logic       load;
  logic       pause;
  logic [3:0] preset_tens;
  logic [3:0] preset_ones;
  logic       done;
  logic [6:0] seg1;
  logic [6:0] seg0;

  int checks   = 0;
  int failures = 0;

  countdown_timer #(.TICK_CYCLES(4)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .en          (en),
    .load        (load),
    .pause       (pause),
    .preset_tens (preset_tens),
    .preset_ones (preset_ones),
    .done        (done),
    .seg1        (seg1),
    .seg0        (seg0)
  );

  always #5 clk = ~clk;

  // Expected active-low pattern for a decimal digit; anything else is blank.
  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Advance n clock edges, leaving time 1 ns after the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse load for one edge; returns just after the load edge.
  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    preset_tens = t;
    preset_ones = o;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    clrn = 1'b0; en = 1'b0; load = 1'b0; pause = 1'b0;
    preset_tens = 4'd0; preset_ones = 4'd0;
    cyc(1);
    exp = {seg_pat(0), seg_pat(0)};
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL reset: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end
    clrn = 1'b1; en = 1'b1;
    cyc(5);
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_hold: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end
  endtask

  task automatic test_basic();
    logic [13:0] exp;
    do_load(4'd0, 4'd3);          // load edge L
    cyc(1);                       // L+1
    checks++;
    exp = {seg_pat(0), seg_pat(3)};
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL basic_03: seg=%b expected %b", {seg1, seg0}, exp);
    end
    cyc(3);                       // L+4: decrement edge, display lags
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL basic_03_hold: seg=%b expected %b", {seg1, seg0}, exp);
    end
    cyc(1);                       // L+5
    checks++;
    exp = {seg_pat(0), seg_pat(2)};
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL basic_02: seg=%b expected %b", {seg1, seg0}, exp);
    end
    cyc(4);                       // L+9
    checks++;
    exp = {seg_pat(0), seg_pat(1)};
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL basic_01: seg=%b expected %b", {seg1, seg0}, exp);
    end
    cyc(3);                       // L+12: reaches 00, EXPIRED, done not yet
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_pre_done: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end
    for (int j = 0; j < 21; j++) begin
      cyc(1);                     // L+13+j
      exp = {seg_pat(0), seg_pat(0)};
`ifdef COUNTDOWN_BLINK_EN
      if (((j / 4) % 2) == 1) exp = {7'b1111111, 7'b1111111};
`endif
      checks++;
      if ({seg1, seg0} !== exp || done !== 1'b1) begin
        failures++;
        $display("FAIL basic_expired[%0d]: seg=%b done=%b expected seg=%b done=1", j, {seg1, seg0}, done, exp);
      end
    end
  endtask

  task automatic test_borrow_clamp();
    logic [13:0] exp;
    do_load(4'd1, 4'd0);          // L
    cyc(4);                       // L+4
    exp = {seg_pat(1), seg_pat(0)};
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL borrow_10: seg=%b expected %b", {seg1, seg0}, exp);
    end
    cyc(1);                       // L+5
    exp = {seg_pat(0), seg_pat(9)};
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL borrow_09: seg=%b expected %b", {seg1, seg0}, exp);
    end
    do_load(4'hC, 4'd5);
    cyc(1);
    exp = {seg_pat(9), seg_pat(5)};
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL clamp_tens: seg=%b expected %b", {seg1, seg0}, exp);
    end
    do_load(4'd2, 4'hF);
    cyc(1);
    exp = {seg_pat(2), seg_pat(9)};
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL clamp_ones: seg=%b expected %b", {seg1, seg0}, exp);
    end
  endtask

  task automatic test_pause();
    logic [13:0] exp;
    do_load(4'd0, 4'd5);          // L
    cyc(4);                       // L+4: 05 -> 04
    pause = 1'b1;
    exp = {seg_pat(0), seg_pat(4)};
    for (int i = 0; i < 10; i++) begin
      cyc(1);                     // L+5 .. L+14
      checks++;
      if ({seg1, seg0} !== exp) begin
        failures++; $display("FAIL pause_hold[%0d]: seg=%b expected %b", i, {seg1, seg0}, exp);
      end
    end
    pause = 1'b0;
    cyc(5);                       // release edge L+15, decrement at L+19
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL pause_resume_04: seg=%b expected %b", {seg1, seg0}, exp);
    end
    cyc(1);                       // L+20
    exp = {seg_pat(0), seg_pat(3)};
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL pause_resume_03: seg=%b expected %b", {seg1, seg0}, exp);
    end
  endtask

  task automatic test_collisions();
    logic [13:0] exp;
    do_load(4'd0, 4'd9);          // L
    cyc(3);                       // L+3: next edge is a tick
    do_load(4'd0, 4'd7);          // L+4: load beats tick
    cyc(1);                       // L+5
    exp = {seg_pat(0), seg_pat(7)};
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL load_vs_tick: seg=%b expected %b", {seg1, seg0}, exp);
    end
    cyc(3);                       // L+8
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL load_full_second: seg=%b expected %b", {seg1, seg0}, exp);
    end
    cyc(1);                       // L+9
    exp = {seg_pat(0), seg_pat(6)};
    checks++;
    if ({seg1, seg0} !== exp) begin
      failures++; $display("FAIL load_then_06: seg=%b expected %b", {seg1, seg0}, exp);
    end

    do_load(4'd0, 4'd0);          // straight to EXPIRED
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL load00_done_lag: done=%b expected 0", done);
    end
    cyc(1);
    exp = {seg_pat(0), seg_pat(0)};
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b1) begin
      failures++;
      $display("FAIL load00_expired: seg=%b done=%b expected seg=%b done=1", {seg1, seg0}, done, exp);
    end
    en = 1'b0;
    cyc(1);
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL en_off_expired: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end

    en = 1'b1;
    do_load(4'd0, 4'd5);
    cyc(6);
    en = 1'b0;
    cyc(1);
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL en_off_midrun: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end
    do_load(4'd0, 4'd8);          // ignored while en=0
    cyc(2);
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL load_while_disabled: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end
    en = 1'b1;
    cyc(9);
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_enable: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end
  endtask

  task automatic test_reset_midrun();
    logic [13:0] exp;
    do_load(4'd4, 4'd2);
    cyc(2);
    clrn = 1'b0;
    cyc(1);
    clrn = 1'b1;
    exp = {seg_pat(0), seg_pat(0)};
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_midrun: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end
    cyc(6);
    checks++;
    if ({seg1, seg0} !== exp || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_midrun_idle: seg=%b done=%b expected seg=%b done=0", {seg1, seg0}, done, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_clamp();
    test_pause();
    test_collisions();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
